// File: rtl/population_evaluation_scheduler_if.sv
// Population evaluation scheduler bus.
// Host, processor and fitness signals grouped for the scheduler.
interface population_evaluation_scheduler_if #(
  parameter int IDX_W = 4
);
  logic             iStartGeneration;
  logic [7:0]       iPopulationSize;
  logic [IDX_W-1:0] oChromIndex;
  logic             oStartProcessing;
  logic             iReadyToProcess;
  logic             iDoneProcessing;
  logic [255:0]     iErrorSums;
  logic             oDoneProcessingFeedback;
  logic             oFitnessValid;
  logic [31:0]      oFitness;
  logic [IDX_W-1:0] oFitnessIndex;
  logic [IDX_W-1:0] oBestIndex;
  logic [31:0]      oBestFitness;
  logic             oBusy;
  logic             oGenerationDone;
  logic             oAborted;

  modport master (
    output iStartGeneration,
    output iPopulationSize,
    output iReadyToProcess,
    output iDoneProcessing,
    output iErrorSums,
    input  oChromIndex,
    input  oStartProcessing,
    input  oDoneProcessingFeedback,
    input  oFitnessValid,
    input  oFitness,
    input  oFitnessIndex,
    input  oBestIndex,
    input  oBestFitness,
    input  oBusy,
    input  oGenerationDone,
    input  oAborted
  );

  modport slave (
    input  iStartGeneration,
    input  iPopulationSize,
    input  iReadyToProcess,
    input  iDoneProcessing,
    input  iErrorSums,
    output oChromIndex,
    output oStartProcessing,
    output oDoneProcessingFeedback,
    output oFitnessValid,
    output oFitness,
    output oFitnessIndex,
    output oBestIndex,
    output oBestFitness,
    output oBusy,
    output oGenerationDone,
    output oAborted
  );
endinterface

// File: rtl/population_evaluation_scheduler.sv
// Population evaluation scheduler.
// Runs each chromosome through the processor and reduces its fitness.
module population_evaluation_scheduler #(
  parameter int POP_SIZE       = 16,
  parameter int IDX_W          = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic iClock,
  input  logic iReset_n,
  population_evaluation_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_WAIT,
    S_SUM,
    S_ACK,
    S_DONE
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W:0] POP_MAX =
    (IDX_W + 1)'(POP_SIZE);
  localparam logic [IDX_W:0] ONE =
    (IDX_W + 1)'(1);

  state_t state;
  state_t next;

  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   size;
  logic [WD_W-1:0]  wd;
  logic [31:0]      fit;
  logic [IDX_W-1:0] fit_idx;
  logic [31:0]      best_fit;
  logic [IDX_W-1:0] best_idx;
  logic             aborted;
  logic             first_ack;

  logic [IDX_W:0] size_in;
  logic [34:0]    sum;
  logic [31:0]    fit_sat;
  logic           last;
  logic           timeout;

  // Clamp the requested population to the table size
  always_comb begin
    size_in = (IDX_W + 1)'(bus.iPopulationSize);
    if (bus.iPopulationSize > 8'(POP_SIZE))
      size_in = POP_MAX;
  end

  // Wide reduction of the eight error sums with saturation
  always_comb begin
    sum = '0;
    for (int k = 0; k < 8; k++)
      sum = sum + {3'b000, bus.iErrorSums[32*k +: 32]};
    fit_sat = sum[31:0];
    if (sum > 35'h0_FFFF_FFFF)
      fit_sat = '1;
  end

  assign last    = ({1'b0, idx} == (size - ONE));
  assign timeout = (wd == WD_LAST);

  // State register
  always_ff @(posedge iClock) begin
    if (!iReset_n)
      state <= S_IDLE;
    else
      state <= next;
  end

  // Next-state decode
  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:
        if (bus.iStartGeneration)
          next = (size_in == '0) ? S_DONE : S_LOAD;
      S_LOAD:
        next = S_ARM;
      S_ARM:
        if (bus.iReadyToProcess)
          next = S_WAIT;
      S_WAIT:
        if (bus.iDoneProcessing)
          next = S_SUM;
        else if (timeout)
          next = S_DONE;
      S_SUM:
        next = S_ACK;
      S_ACK:
        if (!bus.iDoneProcessing)
          next = last ? S_DONE : S_LOAD;
      S_DONE:
        next = S_IDLE;
      default:
        next = S_IDLE;
    endcase
  end

  // Index, watchdog, fitness and best-so-far tracking
  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      idx       <= '0;
      size      <= '0;
      wd        <= '0;
      fit       <= '0;
      fit_idx   <= '0;
      best_fit  <= '1;
      best_idx  <= '0;
      aborted   <= 1'b0;
      first_ack <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.iStartGeneration) begin
            size     <= size_in;
            idx      <= '0;
            best_fit <= '1;
            best_idx <= '0;
            aborted  <= 1'b0;
          end
        end
        S_ARM: begin
          wd <= '0;
        end
        S_WAIT: begin
          if (!bus.iDoneProcessing) begin
            if (timeout)
              aborted <= 1'b1;
            else
              wd <= wd + 1'b1;
          end
        end
        S_SUM: begin
          fit       <= fit_sat;
          fit_idx   <= idx;
          first_ack <= 1'b1;
        end
        S_ACK: begin
          first_ack <= 1'b0;
          if (first_ack && (fit < best_fit)) begin
            best_fit <= fit;
            best_idx <= fit_idx;
          end
          if (!bus.iDoneProcessing && !last)
            idx <= idx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.oChromIndex      = idx;
  assign bus.oStartProcessing =
    (state == S_ARM) & bus.iReadyToProcess;
  assign bus.oDoneProcessingFeedback = (state == S_ACK);
  assign bus.oFitnessValid    = (state == S_ACK) & first_ack;
  assign bus.oFitness         = fit;
  assign bus.oFitnessIndex    = fit_idx;
  assign bus.oBestIndex       = best_idx;
  assign bus.oBestFitness     = best_fit;
  assign bus.oBusy            = (state != S_IDLE);
  assign bus.oGenerationDone  = (state == S_DONE);
  assign bus.oAborted         = aborted;

endmodule

// File: tb/tb_population_evaluation_scheduler.sv
// Testbench for population_evaluation_scheduler.
// Scoreboard-checked directed generations against a processor stub.
module tb_population_evaluation_scheduler;
  localparam int IDX_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  population_evaluation_scheduler_if #(.IDX_W(IDX_W)) bus ();

  population_evaluation_scheduler #(
    .POP_SIZE(16),
    .IDX_W(IDX_W),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .iClock(clk),
    .iReset_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] fit;
  } fit_t;

  typedef struct packed {
    logic        ab;
    logic [3:0]  idx;
    logic [31:0] fit;
  } gen_t;

  fit_t fit_q[$];
  gen_t gen_q[$];
  int checks = 0;
  int fails = 0;

  logic [255:0] tab[16];
  int  rdy_wait = 0;
  bit  never_done = 0;
  bit  stub_abort = 0;
  int  eval_cycles = 3;
  int  st = 0;
  int  cnt = 0;
  int  starts = 0;
  bit  prev_start = 0;
  time gen_time = 0;
  fit_t fe;
  gen_t ge;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic exp_fit(input int i, input logic [31:0] f);
    fit_q.push_back({4'(i), f});
  endtask

  task automatic exp_gen(input logic a, input int i,
                         input logic [31:0] f);
    gen_q.push_back({a, 4'(i), f});
  endtask

  task automatic clear_tab();
    for (int i = 0; i < 16; i++) tab[i] = '0;
  endtask

  // Processor stub: ready in idle, busy for a few cycles, then done
  initial begin
    bus.iReadyToProcess = 1'b0;
    bus.iDoneProcessing = 1'b0;
    bus.iErrorSums = '0;
    forever begin
      @(negedge clk);
      if (stub_abort) begin
        st = 0;
        bus.iReadyToProcess = 1'b0;
        bus.iDoneProcessing = 1'b0;
      end else begin
        case (st)
          0: begin
            if (rdy_wait > 0) begin
              rdy_wait--;
              bus.iReadyToProcess = 1'b0;
            end else begin
              bus.iReadyToProcess = 1'b1;
              #1;
              if (bus.oStartProcessing) begin
                st = 1;
                cnt = eval_cycles;
              end
            end
          end
          1: begin
            bus.iReadyToProcess = 1'b0;
            if (!never_done) begin
              if (cnt == 0) begin
                bus.iErrorSums = tab[bus.oChromIndex];
                bus.iDoneProcessing = 1'b1;
                st = 2;
              end else begin
                cnt--;
              end
            end
          end
          2: if (bus.oDoneProcessingFeedback) st = 3;
          default: begin
            bus.iDoneProcessing = 1'b0;
            st = 0;
          end
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on every strobe
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (bus.oStartProcessing) begin
        starts++;
        if (prev_start)
          check("start_one_cycle", 64'(prev_start), 64'(0));
      end
      prev_start = bus.oStartProcessing;
      if (bus.oFitnessValid) begin
        if (fit_q.size() == 0) begin
          check("fitness_unexpected", 64'(1), 64'(0));
        end else begin
          fe = fit_q.pop_front();
          check("fitness_index", 64'(bus.oFitnessIndex),
                64'(fe.idx));
          check("fitness_value", 64'(bus.oFitness),
                64'(fe.fit));
        end
      end
      if (bus.oGenerationDone) begin
        gen_time = $time;
        if (gen_q.size() == 0) begin
          check("gen_done_unexpected", 64'(1), 64'(0));
        end else begin
          ge = gen_q.pop_front();
          check("gen_aborted", 64'(bus.oAborted), 64'(ge.ab));
          check("gen_best_index", 64'(bus.oBestIndex),
                64'(ge.idx));
          check("gen_best_fitness", 64'(bus.oBestFitness),
                64'(ge.fit));
        end
      end
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic run_gen(input logic [7:0] size);
    @(negedge clk);
    bus.iPopulationSize = size;
    bus.iStartGeneration = 1'b1;
    @(negedge clk);
    bus.iStartGeneration = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.oBusy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000)
      check({name, "_idle_timeout"}, 64'(1), 64'(0));
    @(negedge clk);
    check({name, "_fit_q_empty"}, 64'(fit_q.size()), 64'(0));
    check({name, "_gen_q_empty"}, 64'(gen_q.size()), 64'(0));
  endtask

  task automatic wait_launch(output bit ok);
    int n;
    n = 0;
    while (st != 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (st == 1);
  endtask

  task automatic stub_reset();
    stub_abort = 1'b1;
    repeat (2) @(negedge clk);
    stub_abort = 1'b0;
    never_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int s0;
    int n;
    bit ok;
    time t0;
    bus.iStartGeneration = 1'b0;
    bus.iPopulationSize = '0;
    clear_tab();
    repeat (3) @(negedge clk);

    check("rst_busy", 64'(bus.oBusy), 64'(0));
    check("rst_best_fit", 64'(bus.oBestFitness),
          64'(32'hFFFF_FFFF));
    check("rst_best_idx", 64'(bus.oBestIndex), 64'(0));
    check("rst_fitness", 64'(bus.oFitness), 64'(0));
    check("rst_chrom_idx", 64'(bus.oChromIndex), 64'(0));
    check("rst_aborted", 64'(bus.oAborted), 64'(0));
    check("rst_feedback", 64'(bus.oDoneProcessingFeedback),
          64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // size 3: totals 5, 2, 2 -> tie keeps index 1
    clear_tab();
    for (int k = 0; k < 5; k++) tab[0][32*k +: 32] = 32'd1;
    tab[1][31:0] = 32'd2;
    tab[2][255:224] = 32'd2;
    exp_fit(0, 32'd5);
    exp_fit(1, 32'd2);
    exp_fit(2, 32'd2);
    exp_gen(1'b0, 1, 32'd2);
    s0 = starts;
    run_gen(8'd3);
    wait_idle("gen3");
    check("gen3_starts", 64'(starts - s0), 64'(3));
    check("gen3_best_hold", 64'(bus.oBestFitness), 64'(2));

    // all-ones sums saturate; tie at max keeps index 0
    for (int i = 0; i < 16; i++) tab[i] = '1;
    exp_fit(0, 32'hFFFF_FFFF);
    exp_fit(1, 32'hFFFF_FFFF);
    exp_gen(1'b0, 0, 32'hFFFF_FFFF);
    run_gen(8'd2);
    wait_idle("sat");

    // exact max vs one-over-max vs small
    clear_tab();
    tab[0][31:0]  = 32'h8000_0000;
    tab[0][63:32] = 32'h7FFF_FFFF;
    tab[1][31:0]  = 32'h8000_0000;
    tab[1][63:32] = 32'h8000_0000;
    tab[2][191:160] = 32'd7;
    exp_fit(0, 32'hFFFF_FFFF);
    exp_fit(1, 32'hFFFF_FFFF);
    exp_fit(2, 32'd7);
    exp_gen(1'b0, 2, 32'd7);
    run_gen(8'd3);
    wait_idle("edge");

    // processor not ready for 10 cycles while armed
    clear_tab();
    tab[0][95:64] = 32'd9;
    exp_fit(0, 32'd9);
    exp_gen(1'b0, 0, 32'd9);
    s0 = starts;
    rdy_wait = 10;
    run_gen(8'd1);
    repeat (6) @(negedge clk);
    check("hold_no_start", 64'(starts - s0), 64'(0));
    check("hold_busy", 64'(bus.oBusy), 64'(1));
    wait_idle("hold");
    check("hold_starts", 64'(starts - s0), 64'(1));

    // watchdog: done never comes
    never_done = 1'b1;
    exp_gen(1'b1, 0, 32'hFFFF_FFFF);
    s0 = starts;
    run_gen(8'd2);
    wait_launch(ok);
    check("wd_launched", 64'(ok), 64'(1));
    n = 0;
    while (!bus.oAborted && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wd_cycles", 64'(n), 64'(50));
    wait_idle("wd");
    check("wd_starts", 64'(starts - s0), 64'(1));
    check("wd_sticky", 64'(bus.oAborted), 64'(1));
    stub_reset();

    // empty population
    exp_gen(1'b0, 0, 32'hFFFF_FFFF);
    s0 = starts;
    @(negedge clk);
    t0 = $time;
    run_gen(8'd0);
    wait_idle("empty");
    check("empty_starts", 64'(starts - s0), 64'(0));
    check("empty_latency_ok",
          64'(((gen_time - t0) / 10) inside {[1:2]}), 64'(1));
    check("empty_abort_clr", 64'(bus.oAborted), 64'(0));

    // oversize population clamps to 16
    clear_tab();
    for (int i = 0; i < 16; i++) begin
      tab[i][127:96] = 32'(100 - 3 * i);
      exp_fit(i, 32'(100 - 3 * i));
    end
    exp_gen(1'b0, 15, 32'd55);
    s0 = starts;
    run_gen(8'd200);
    wait_idle("clamp");
    check("clamp_starts", 64'(starts - s0), 64'(16));

    // reset in the middle of an evaluation
    never_done = 1'b1;
    run_gen(8'd3);
    wait_launch(ok);
    check("rstmid_launched", 64'(ok), 64'(1));
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_busy", 64'(bus.oBusy), 64'(0));
    check("rstmid_best_fit", 64'(bus.oBestFitness),
          64'(32'hFFFF_FFFF));
    check("rstmid_valid", 64'(bus.oFitnessValid), 64'(0));
    check("rstmid_gen_done", 64'(bus.oGenerationDone), 64'(0));
    rst_n = 1'b1;
    stub_reset();
    repeat (5) @(negedge clk);
    check("rstmid_idle", 64'(bus.oBusy), 64'(0));
    check("end_fit_q_empty", 64'(fit_q.size()), 64'(0));
    check("end_gen_q_empty", 64'(gen_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
